// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a one-entry ID slot, regfile read addressing,
// writeback bypass, load-use stall and a valid/ready ID/EX pipeline register.
module id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_valid_i,
   output logic        if_ready_o,
   input  logic [31:0] if_pc_i,
   input  logic [31:0] if_inst_i,
   input  logic        flush_i,
   output logic [31:0] rf_raddr1_o,
   output logic [31:0] rf_raddr2_o,
   input  logic [31:0] rf_rdata1_i,
   input  logic [31:0] rf_rdata2_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_waddr_i,
   input  logic [31:0] wb_wdata_i,
   input  logic        ex_ready_i,
   output logic        ex_valid_o,
   output logic [31:0] ex_pc_o,
   output logic [6:0]  ex_opcode_o,
   output logic [2:0]  ex_funct3_o,
   output logic        ex_funct7b5_o,
   output logic [4:0]  ex_rs1_o,
   output logic [4:0]  ex_rs2_o,
   output logic [31:0] ex_rs1_data_o,
   output logic [31:0] ex_rs2_data_o,
   output logic [31:0] ex_imm_o,
   output logic [4:0]  ex_rd_o,
   output logic        ex_rd_we_o,
   output logic        ex_is_load_o,
   output logic        ex_illegal_o
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic        slot_valid;
   logic [31:0] slot_pc, slot_inst;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic        i_type, s_type, b_type, u_type, j_type, legal, uses_rs1, uses_rs2, rd_we;
   logic [31:0] imm, rs1_data, rs2_data;
   logic        hazard, ex_load, id_fire, if_take;

   assign opcode = slot_inst[6:0];
   assign rd     = slot_inst[11:7];
   assign funct3 = slot_inst[14:12];
   assign rs1    = slot_inst[19:15];
   assign rs2    = slot_inst[24:20];

   always_comb begin
      i_type   = opcode inside {OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM};
      s_type   = opcode == OP_STORE;
      b_type   = opcode == OP_BRANCH;
      u_type   = opcode inside {OP_LUI, OP_AUIPC};
      j_type   = opcode == OP_JAL;
      legal    = i_type || s_type || b_type || u_type || j_type || opcode inside {OP_OP, OP_FENCE};
      uses_rs1 = !(u_type || j_type);
      uses_rs2 = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
      rd_we    = rd != 5'd0 && (u_type || j_type || opcode inside {OP_JALR, OP_LOAD, OP_IMM, OP_OP});
      imm      = i_type ? {{20{slot_inst[31]}}, slot_inst[31:20]} :
                 s_type ? {{20{slot_inst[31]}}, slot_inst[31:25], slot_inst[11:7]} :
                 b_type ? {{19{slot_inst[31]}}, slot_inst[31], slot_inst[7], slot_inst[30:25], slot_inst[11:8], 1'b0} :
                 u_type ? {slot_inst[31:12], 12'b0} :
                 j_type ? {{11{slot_inst[31]}}, slot_inst[31], slot_inst[19:12], slot_inst[20], slot_inst[30:21], 1'b0} :
                 32'b0;
   end

   // Addresses follow the incoming beat so read data lines up with the slot next cycle
   always_comb begin
      hazard      = slot_valid && ex_valid_o && ex_is_load_o && ex_rd_o != 5'd0 &&
                    ((uses_rs1 && rs1 == ex_rd_o) || (uses_rs2 && rs2 == ex_rd_o));
      ex_load     = !ex_valid_o || ex_ready_i;
      id_fire     = slot_valid && !hazard && ex_load;
      if_ready_o  = flush_i || !slot_valid || id_fire;
      if_take     = if_valid_i && if_ready_o;
      rf_raddr1_o = {27'b0, if_take ? if_inst_i[19:15] : rs1};
      rf_raddr2_o = {27'b0, if_take ? if_inst_i[24:20] : rs2};
      rs1_data    = rs1 == 5'd0 ? 32'b0 : (wb_we_i && wb_waddr_i == rs1) ? wb_wdata_i : rf_rdata1_i;
      rs2_data    = rs2 == 5'd0 ? 32'b0 : (wb_we_i && wb_waddr_i == rs2) ? wb_wdata_i : rf_rdata2_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_valid <= 1'b0;
         slot_pc    <= RESET_PC;
         slot_inst  <= 32'b0;
      end else if (flush_i) begin
         slot_valid <= 1'b0;
      end else if (if_ready_o) begin
         slot_valid <= if_valid_i;
         if (if_valid_i) begin
            slot_pc   <= if_pc_i;
            slot_inst <= if_inst_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_valid_o    <= 1'b0;
         ex_pc_o       <= RESET_PC;
         ex_opcode_o   <= 7'b0;
         ex_funct3_o   <= 3'b0;
         ex_funct7b5_o <= 1'b0;
         ex_rs1_o      <= 5'b0;
         ex_rs2_o      <= 5'b0;
         ex_rs1_data_o <= 32'b0;
         ex_rs2_data_o <= 32'b0;
         ex_imm_o      <= 32'b0;
         ex_rd_o       <= 5'b0;
         ex_rd_we_o    <= 1'b0;
         ex_is_load_o  <= 1'b0;
         ex_illegal_o  <= 1'b0;
      end else if (flush_i) begin
         ex_valid_o <= 1'b0;
      end else if (ex_load) begin
         ex_valid_o <= slot_valid && !hazard;
         if (id_fire) begin
            ex_pc_o       <= slot_pc;
            ex_opcode_o   <= opcode;
            ex_funct3_o   <= funct3;
            ex_funct7b5_o <= slot_inst[30];
            ex_rs1_o      <= rs1;
            ex_rs2_o      <= rs2;
            ex_rs1_data_o <= rs1_data;
            ex_rs2_data_o <= rs2_data;
            ex_imm_o      <= imm;
            ex_rd_o       <= rd;
            ex_rd_we_o    <= rd_we;
            ex_is_load_o  <= opcode == OP_LOAD;
            ex_illegal_o  <= !legal;
         end
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage with an architectural register model,
// directed scenarios and randomized streaming with stalls, writebacks and flushes.
module tb_id_stage;
   localparam logic [31:0] RPC = 32'h0000_1000;
   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011, IMM = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011, FENCE = 7'b0001111, SYSTEM = 7'b1110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, if_valid, if_ready, flush, wb_we, ex_ready, ex_valid;
   logic [31:0] if_pc, if_inst, raddr1, raddr2, rdata1, rdata2, wb_wdata;
   logic [4:0]  wb_waddr, ex_rs1, ex_rs2, ex_rd;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_rd_we, ex_is_load, ex_illegal;

   id_stage #(.RESET_PC(RPC)) dut (
      .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
      .if_pc_i(if_pc), .if_inst_i(if_inst), .flush_i(flush),
      .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2), .rf_rdata1_i(rdata1), .rf_rdata2_i(rdata2),
      .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .ex_ready_i(ex_ready),
      .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_opcode_o(ex_opcode), .ex_funct3_o(ex_funct3),
      .ex_funct7b5_o(ex_funct7b5), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
      .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm),
      .ex_rd_o(ex_rd), .ex_rd_we_o(ex_rd_we), .ex_is_load_o(ex_is_load), .ex_illegal_o(ex_illegal)
   );

   typedef struct { logic [31:0] pc, inst; int acc; } ent_t;
   typedef struct {
      logic [31:0] pc, imm, d1, d2;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rs1, rs2, rd;
      logic        b5, we, ld, ill;
   } xp_t;

   ent_t        q[$];
   xp_t         cur;
   int          checks = 0, errors = 0, cyc = 0;
   bit          mon_en = 0;
   logic [31:0] mem [32];

   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read regfile; a write on the same edge is visible to that read
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i * 7);
         rdata1 <= 32'b0;
         rdata2 <= 32'b0;
      end else begin
         rdata1 <= (wb_we && wb_waddr == raddr1[4:0]) ? wb_wdata : mem[raddr1[4:0]];
         rdata2 <= (wb_we && wb_waddr == raddr2[4:0]) ? wb_wdata : mem[raddr2[4:0]];
         if (wb_we) mem[wb_waddr] <= wb_wdata;
      end
   end

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] o);
      return o inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMM, OPR, FENCE, SYSTEM};
   endfunction

   function automatic bit depends(input logic [31:0] w, input logic [4:0] r);
      bit u1, u2;
      u1 = !(w[6:0] inside {LUI, AUIPC, JAL});
      u2 = w[6:0] inside {OPR, STORE, BRANCH};
      return (u1 && w[19:15] == r) || (u2 && w[24:20] == r);
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      int v;
      case (w[6:0])
         JALR, LOAD, IMM, SYSTEM: begin v = $signed(w[31:20]); return v; end
         STORE:                   begin v = $signed({w[31:25], w[11:7]}); return v; end
         BRANCH:                  begin v = $signed({w[31], w[7], w[30:25], w[11:8]}); return v * 2; end
         JAL:                     begin v = $signed({w[31], w[19:12], w[20], w[30:21]}); return v * 2; end
         LUI, AUIPC:              return w & 32'hFFFF_F000;
         default:                 return 32'b0;
      endcase
   endfunction

   function automatic xp_t mk(input logic [31:0] pc, input logic [31:0] w);
      xp_t x;
      x.pc  = pc;
      x.op  = w[6:0];
      x.f3  = w[14:12];
      x.b5  = w[30];
      x.rs1 = w[19:15];
      x.rs2 = w[24:20];
      x.rd  = w[11:7];
      x.ill = !is_legal(w[6:0]);
      x.ld  = w[6:0] == LOAD;
      x.we  = x.rd != 5'd0 && w[6:0] inside {LUI, AUIPC, JAL, JALR, LOAD, IMM, OPR};
      x.imm = ref_imm(w);
      x.d1  = x.rs1 == 5'd0 ? 32'b0 : mem[x.rs1];
      x.d2  = x.rs2 == 5'd0 ? 32'b0 : mem[x.rs2];
      return x;
   endfunction

   task automatic cmp(input xp_t x);
      chk("ex_pc", ex_pc, x.pc);
      chk("ex_opcode", ex_opcode, x.op);
      chk("ex_funct3", ex_funct3, x.f3);
      chk("ex_funct7b5", ex_funct7b5, x.b5);
      chk("ex_rs1", ex_rs1, x.rs1);
      chk("ex_rs2", ex_rs2, x.rs2);
      chk("ex_rd", ex_rd, x.rd);
      chk("ex_rd_we", ex_rd_we, x.we);
      chk("ex_is_load", ex_is_load, x.ld);
      chk("ex_illegal", ex_illegal, x.ill);
      chk("ex_rs1_data", ex_rs1_data, x.d1);
      chk("ex_rs2_data", ex_rs2_data, x.d2);
      if (!x.ill) chk("ex_imm", ex_imm, x.imm);
   endtask

   // Monitor: each new ID/EX entry is matched against the oldest accepted beat
   initial begin
      bit   pv, pl, pf;
      ent_t e;
      xp_t  x;
      pv = 0; pl = 1; pf = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pv = 0; pl = 1; pf = 0;
         end else begin
            if (pf) chk("flush_kills_ex", ex_valid, 0);
            else if (!pl) begin
               chk("hold_valid", ex_valid, pv);
               if (pv) cmp(cur);
            end else if (ex_valid) begin
               chk("issue_has_beat", q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("load_use_issue", pv && cur.ld && cur.rd != 5'd0 && depends(e.inst, cur.rd), 0);
                  x = mk(e.pc, e.inst);
                  cmp(x);
                  cur = x;
               end
            end else if (q.size() != 0 && q[0].acc < cyc - 1)
               chk("bubble_justified", pv && cur.ld && cur.rd != 5'd0 && depends(q[0].inst, cur.rd), 1);
            pv = ex_valid;
            pl = !ex_valid || ex_ready;
            pf = flush;
         end
      end
   end

   task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit fl,
                       input bit rdy, input bit we, input logic [4:0] wa, input logic [31:0] wd);
      ent_t e;
      @(posedge clk);
      #1;
      if_valid = v; if_pc = pc; if_inst = inst; flush = fl;
      ex_ready = rdy; wb_we = we; wb_waddr = wa; wb_wdata = wd;
      #3;
      if (v && if_ready && !fl && mon_en) begin
         e.pc = pc; e.inst = inst; e.acc = cyc;
         q.push_back(e);
      end
      #2;
      if (fl) q.delete();
   endtask

   task automatic idle(input bit rdy);
      step(0, 32'b0, 32'b0, 0, rdy, 0, 5'd0, 32'b0);
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] w;
      logic [6:0]  o;
      case ($urandom_range(0, 13))
         0: o = LUI;     1: o = AUIPC;  2: o = JAL;    3: o = JALR;
         4: o = BRANCH;  5: o = STORE;  6: o = IMM;    7: o = OPR;
         8: o = FENCE;   9: o = SYSTEM; 10: o = 7'h7F;
         default: o = LOAD;
      endcase
      w = $urandom;
      w[6:0]   = o;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pcv;
      rst_n = 0; if_valid = 0; if_pc = 0; if_inst = 0; flush = 0;
      ex_ready = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_pc", ex_pc, RPC);
      chk("rst_ex_imm", ex_imm, 0);
      chk("rst_ex_rd_we", ex_rd_we, 0);
      chk("rst_ex_rs1_data", ex_rs1_data, 0);
      chk("rst_if_ready", if_ready, 1);
      rst_n = 1;
      mon_en = 1;

      step(1, 32'h100, 32'h0050_0093, 0, 1, 0, 5'd0, 32'b0);
      idle(1);
      idle(1);
      chk("addi_valid", ex_valid, 1);
      chk("addi_rd", ex_rd, 1);
      chk("addi_rd_we", ex_rd_we, 1);
      chk("addi_imm", ex_imm, 5);
      chk("addi_rs1_data", ex_rs1_data, 0);

      step(1, 32'h104, 32'h0000_A103, 0, 1, 0, 5'd0, 32'b0);
      step(1, 32'h108, 32'h0011_01B3, 0, 1, 0, 5'd0, 32'b0);
      idle(1);
      chk("lu_if_ready_stall", if_ready, 0);
      chk("lu_load_in_ex", ex_is_load, 1);
      idle(1);
      chk("lu_bubble", ex_valid, 0);
      idle(1);
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_rd", ex_rd, 3);

      step(1, 32'h10C, 32'h0020_A423, 0, 1, 0, 5'd0, 32'b0);
      step(0, 32'b0, 32'b0, 0, 1, 1, 5'd2, 32'hDEAD_BEEF);
      idle(1);
      chk("sw_rs2_bypass", ex_rs2_data, 32'hDEAD_BEEF);
      chk("sw_imm", ex_imm, 8);
      chk("sw_rd_we", ex_rd_we, 0);

      step(1, 32'h110, 32'hFFDF_F06F, 0, 1, 0, 5'd0, 32'b0);
      step(1, 32'h114, 32'hFFFF_FFFF, 0, 1, 0, 5'd0, 32'b0);
      idle(1);
      chk("jal_imm", ex_imm, 32'hFFFF_FFFC);
      chk("jal_rd_we", ex_rd_we, 0);
      idle(1);
      chk("ill_flag", ex_illegal, 1);
      chk("ill_rd_we", ex_rd_we, 0);
      idle(1);

      step(1, 32'h200, 32'h0090_0213, 0, 0, 0, 5'd0, 32'b0);
      step(1, 32'h204, 32'h0073_02B3, 0, 0, 0, 5'd0, 32'b0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h208, 32'h0050_0093, 0, 0, 0, 5'd0, 32'b0);
         chk("stall_if_ready", if_ready, 0);
         chk("stall_valid", ex_valid, 1);
         chk("stall_pc", ex_pc, 32'h200);
         chk("stall_rd", ex_rd, 4);
         chk("stall_imm", ex_imm, 9);
         chk("stall_raddr1", raddr1, 6);
         chk("stall_raddr2", raddr2, 7);
      end
      step(1, 32'h20C, 32'h0050_0093, 1, 0, 0, 5'd0, 32'b0);
      chk("flush_if_ready", if_ready, 1);
      idle(1);
      chk("flush_ex_invalid", ex_valid, 0);
      chk("flush_slot_empty", if_ready, 1);
      idle(1);
      chk("flush_beat_dropped", ex_valid, 0);

      pcv = 32'h4000;
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 4) != 0, pcv, rnd_inst(), $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         pcv += 4;
      end
      repeat (6) idle(1);
      chk("drain_queue_empty", q.size(), 0);
      chk("drain_ex_invalid", ex_valid, 0);

      step(1, 32'h300, 32'h0050_0093, 0, 1, 0, 5'd0, 32'b0);
      step(1, 32'h304, 32'h0060_0113, 0, 1, 0, 5'd0, 32'b0);
      idle(1);
      @(posedge clk);
      #2;
      chk("pre_reset_valid", ex_valid, 1);
      mon_en = 0;
      rst_n = 0;
      #1;
      chk("async_rst_valid", ex_valid, 0);
      chk("async_rst_pc", ex_pc, RPC);
      chk("async_rst_if_ready", if_ready, 1);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
